piso_shift_reg: RTL and testbench

Parallel-in / serial-out shift register that serialises a loaded word one bit per clock, LSB first by default, back-filling with `ser_in`. It is the bit-serialiser behind the UART transmitter, clocked by the baud-rate clock. The transmitter loads a `{data, start_bit}` frame and reads the line level from `ser_out`. The block holds no framing or handshake logic; it is a pure datapath element.

---
 rtl/uart_pkg.sv | 10 +
 rtl/piso_shift_reg.sv | 53 +++++
 tb/tb_piso_shift_reg.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, idle line level and the frame type
// used by the transmitter datapath.
package uart_pkg;

    localparam int unsigned UART_FRAME_W = 9;
    localparam logic        LINE_IDLE    = 1'b1;

    typedef logic [UART_FRAME_W-1:0] uart_frame_t;

endpackage : uart_pkg

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register: the bit serialiser behind the UART
// transmitter. Loads a word, then shifts it out one bit per clock.
module piso_shift_reg
    import uart_pkg::*;
#(
    parameter int unsigned     WIDTH     = UART_FRAME_W,
    parameter int unsigned     LSB_FIRST = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{LINE_IDLE}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_in,
    input  logic             load,
    output logic             ser_out,
    output logic [WIDTH-1:0] par_out
);

    localparam int OUT_IDX = (LSB_FIRST != 0) ? 0 : int'(WIDTH) - 1;

    if (WIDTH < 2) begin : g_width_check
        $error("piso_shift_reg: WIDTH must be at least 2");
    end

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;

    // The vacated end is back-filled from ser_in so an idle-high ser_in
    // returns the line to idle once the loaded word has drained.
    if (LSB_FIRST != 0) begin : g_lsb_first
        assign shifted = {ser_in, shreg[WIDTH-1:1]};
    end else begin : g_msb_first
        assign shifted = {shreg[WIDTH-2:0], ser_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= RESET_VAL;
        end else if (load) begin
            shreg <= par_in;
        end else begin
            shreg <= shifted;
        end
    end

    assign ser_out = shreg[OUT_IDX];
    assign par_out = shreg;

    a_ser_out_is_end_bit: assert property (@(posedge clk) ser_out == par_out[OUT_IDX]);

    a_load_captures: assert property (@(posedge clk) (load && !rst) |=> (par_out == $past(par_in)));

endmodule : piso_shift_reg

// File: tb/tb_piso_shift_reg.sv
// Scoreboard bench for piso_shift_reg: a default LSB-first 9-bit instance and
// an MSB-first 8-bit instance, driven with directed vectors.
module tb_piso_shift_reg;

    typedef struct {
        logic [8:0] par;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (WIDTH=9, LSB first, reset 9'h1FF)
    logic       a_rst = 1'b1;
    logic       a_load = 1'b0;
    logic [8:0] a_par_in = '0;
    logic       a_ser_in = 1'b1;
    logic       a_ser_out;
    logic [8:0] a_par_out;

    // Instance B: WIDTH=8, MSB first
    logic       b_rst = 1'b1;
    logic       b_load = 1'b0;
    logic [7:0] b_par_in = '0;
    logic       b_ser_in = 1'b0;
    logic       b_ser_out;
    logic [7:0] b_par_out;

    piso_shift_reg dut_a (
        .clk     (clk),
        .rst     (a_rst),
        .par_in  (a_par_in),
        .ser_in  (a_ser_in),
        .load    (a_load),
        .ser_out (a_ser_out),
        .par_out (a_par_out)
    );

    piso_shift_reg #(.WIDTH(8), .LSB_FIRST(0)) dut_b (
        .clk     (clk),
        .rst     (b_rst),
        .par_in  (b_par_in),
        .ser_in  (b_ser_in),
        .load    (b_load),
        .ser_out (b_ser_out),
        .par_out (b_par_out)
    );

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // One clock of stimulus on instance A; expected state after that edge.
    task automatic a_cyc(input logic r, input logic l, input logic [8:0] p,
                         input logic s, input logic [8:0] e, input string n);
        @(negedge clk);
        a_rst = r; a_load = l; a_par_in = p; a_ser_in = s;
        qa.push_back('{par: e, name: n});
    endtask

    task automatic b_cyc(input logic r, input logic l, input logic [7:0] p,
                         input logic s, input logic [7:0] e, input string n);
        @(negedge clk);
        b_rst = r; b_load = l; b_par_in = p; b_ser_in = s;
        qb.push_back('{par: {1'b0, e}, name: n});
    endtask

    // Monitor: compares both instances just after every rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                x = qa.pop_front();
                check({x.name, "_a_par"}, a_par_out, x.par);
                check({x.name, "_a_ser"}, {8'd0, a_ser_out}, {8'd0, x.par[0]});
            end
            if (qb.size() > 0) begin
                x = qb.pop_front();
                check({x.name, "_b_par"}, {1'b0, b_par_out}, x.par);
                check({x.name, "_b_ser"}, {8'd0, b_ser_out}, {8'd0, x.par[7]});
            end
        end
    end

    // Instance A stimulus
    initial begin
        logic [8:0] frame_seq [10];
        frame_seq = '{9'h1A5, 9'h1D2, 9'h1E9, 9'h1F4, 9'h1FA,
                      9'h1FD, 9'h1FE, 9'h1FF, 9'h1FF, 9'h1FF};

        a_cyc(1, 1, 9'h000, 1, 9'h1FF, "reset0");
        a_cyc(1, 1, 9'h000, 1, 9'h1FF, "reset1");

        a_cyc(0, 1, 9'h14A, 1, 9'h14A, "frame_load");
        for (int i = 0; i < 10; i++)
            a_cyc(0, 0, 9'h000, 1, frame_seq[i], $sformatf("frame_shift%0d", i + 1));

        a_cyc(0, 1, 9'h000, 1, 9'h000, "reload_first");
        a_cyc(0, 0, 9'h000, 1, 9'h100, "reload_sh1");
        a_cyc(0, 0, 9'h000, 1, 9'h180, "reload_sh2");
        a_cyc(0, 0, 9'h000, 1, 9'h1C0, "reload_sh3");
        a_cyc(0, 1, 9'h1FF, 1, 9'h1FF, "reload_second");

        a_cyc(0, 1, 9'h000, 0, 9'h000, "fill_load");
        for (int i = 0; i < 9; i++)
            a_cyc(0, 0, 9'h1FF, 0, 9'h000, $sformatf("fill_zero%0d", i + 1));
        a_cyc(0, 0, 9'h000, 1, 9'h100, "fill_one");

        a_cyc(0, 1, 9'h0AA, 1, 9'h0AA, "prio_preload");
        a_cyc(1, 1, 9'h055, 1, 9'h1FF, "prio_rst_load");

        a_cyc(0, 1, 9'h000, 0, 9'h000, "midrst_load");
        a_cyc(0, 0, 9'h000, 0, 9'h000, "midrst_shift");
        a_cyc(1, 0, 9'h000, 0, 9'h1FF, "midrst_rst");

        a_cyc(0, 1, 9'h003, 0, 9'h003, "b2b_load1");
        a_cyc(0, 1, 9'h0F0, 0, 9'h0F0, "b2b_load2");
        a_cyc(0, 0, 9'h000, 0, 9'h078, "b2b_shift");
    end

    // Instance B stimulus
    initial begin
        logic [7:0] msb_seq [8];
        msb_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};

        b_cyc(1, 0, 8'h00, 0, 8'hFF, "msb_reset");
        b_cyc(0, 1, 8'h81, 0, 8'h81, "msb_load");
        for (int i = 0; i < 8; i++)
            b_cyc(0, 0, 8'h00, 0, msb_seq[i], $sformatf("msb_shift%0d", i + 1));
        b_cyc(0, 1, 8'h01, 1, 8'h01, "msb_load2");
        b_cyc(0, 0, 8'h00, 1, 8'h03, "msb_fill");
    end

    // Finish once every expectation has been consumed, with a bounded wait.
    initial begin
        int waited;
        repeat (45) @(negedge clk);
        waited = 0;
        while ((qa.size() > 0 || qb.size() > 0) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("queues_drained", 9'(qa.size() + qb.size()), 9'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_piso_shift_reg
